// File: rtl/data_mem_responder_pkg.sv
// Shared types for the data-memory responder: FSM states, op codes, wait counter width.
// Also holds the byte-address to word-index helper used at request capture.
package data_mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2
    } state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

    localparam int CNT_W = 4;

    // Offset wraps mod 2^32, so addresses below the base land far out of range.
    function automatic logic [29:0] word_index(input logic [31:0] a, input logic [31:0] base);
        return 30'((a - base) >> 2);
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Load/store bus between the decoder (master) and the data-memory responder (slave).
// Level-sensitive request, completion signalled by a single mem_done pulse.
interface data_mem_responder_if #(
    parameter int DATA_W = 32
);
    logic [31:0]       data_memory_a;
    logic [DATA_W-1:0] data_memory_out_v;
    logic              data_memory_read;
    logic              data_memory_write;
    logic [DATA_W-1:0] data_memory_in_v;
    logic              mem_busy;
    logic              mem_done;
    logic              mem_err;

    modport master (
        output data_memory_a, data_memory_out_v, data_memory_read, data_memory_write,
        input  data_memory_in_v, mem_busy, mem_done, mem_err
    );

    modport slave (
        input  data_memory_a, data_memory_out_v, data_memory_read, data_memory_write,
        output data_memory_in_v, mem_busy, mem_done, mem_err
    );
endinterface

// File: rtl/data_mem_responder_mem_array.sv
// Single-port synchronous word RAM, read-before-write, no reset on contents or read register.
// Read data appears the cycle after the address edge; no backpressure.
module data_mem_responder_mem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: captures one word read/write in IDLE, waits WAIT_STATES, accesses the RAM.
// mem_done pulses WAIT_STATES+1 cycles after capture; the initiator stalls on mem_busy until then.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int          DATA_W      = 32,
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input logic                  clk,
    input logic                  rst_n,
    data_mem_responder_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] WAIT_LAST = (WAIT_STATES == 0) ? '0 : CNT_W'(WAIT_STATES - 1);

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic              err_q, err_d;
    logic [AW-1:0]     word_q, word_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              merr_q, merr_d;

    logic              req_any;
    logic [29:0]       word_full;
    op_e               cur_op;
    logic              cur_err;
    logic [AW-1:0]     cur_word;
    logic [DATA_W-1:0] cur_wdata;
    logic              go_access;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;

    data_mem_responder_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk   (clk),
        .we    (ram_we),
        .addr  (cur_word),
        .wdata (cur_wdata),
        .rdata (ram_rdata)
    );

    // The RAM edge is the one entering ACCESS, so the RAM is fed from the live bus
    // on a zero-wait capture and from the latched request otherwise.
    always_comb begin
        req_any   = bus.data_memory_read | bus.data_memory_write;
        word_full = word_index(bus.data_memory_a, BASE_ADDR);
        state_d   = state_q;
        op_d      = op_q;
        err_d     = err_q;
        word_d    = word_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        merr_d    = 1'b0;
        cur_op    = op_q;
        cur_err   = err_q;
        cur_word  = word_q;
        cur_wdata = wdata_q;
        go_access = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy_d = req_any;
                if (req_any) begin
                    cur_op    = bus.data_memory_write ? OP_WR : OP_RD;
                    cur_err   = (bus.data_memory_read & bus.data_memory_write)
                              | (bus.data_memory_a[1:0] != 2'b00)
                              | ({2'b00, word_full} >= 32'(DEPTH));
                    cur_word  = word_full[AW-1:0];
                    cur_wdata = bus.data_memory_out_v;
                    op_d      = cur_op;
                    err_d     = cur_err;
                    word_d    = cur_word;
                    wdata_d   = cur_wdata;
                    cnt_d     = '0;
                    go_access = (WAIT_STATES == 0);
                    state_d   = go_access ? ST_ACCESS : ST_WAIT;
                end
            end
            ST_WAIT: begin
                busy_d = 1'b1;
                if (cnt_q == WAIT_LAST) begin
                    go_access = 1'b1;
                    state_d   = ST_ACCESS;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_ACCESS: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
                if (op_q == OP_RD && !err_q) begin
                    hold_d = ram_rdata;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (go_access) begin
            done_d = 1'b1;
            merr_d = cur_err;
        end
        ram_we = go_access && (cur_op == OP_WR) && !cur_err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_RD;
            err_q   <= 1'b0;
            word_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            hold_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            merr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            err_q   <= err_d;
            word_q  <= word_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            merr_q  <= merr_d;
        end
    end

    // Fresh read data comes straight from the RAM register during the done cycle, then is held.
    assign bus.data_memory_in_v = (state_q == ST_ACCESS && op_q == OP_RD && !err_q) ? ram_rdata : hold_q;
    assign bus.mem_busy         = busy_q;
    assign bus.mem_done         = done_q;
    assign bus.mem_err          = merr_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: three instances with WAIT_STATES 0, 1 and 3.
module tb_data_mem_responder;
    logic clk;
    logic rst_n;

    logic [31:0] a_v   [3];
    logic [31:0] d_v   [3];
    logic        rd_v  [3];
    logic        wr_v  [3];
    logic [31:0] in_v  [3];
    logic        busy_v[3];
    logic        done_v[3];
    logic        err_v [3];

    int n_chk  = 0;
    int n_pass = 0;

    data_mem_responder_if #(.DATA_W(32)) if_ws0 ();
    data_mem_responder_if #(.DATA_W(32)) if_ws1 ();
    data_mem_responder_if #(.DATA_W(32)) if_ws3 ();

    data_mem_responder #(.WAIT_STATES(0)) u_ws0 (.clk(clk), .rst_n(rst_n), .bus(if_ws0));
    data_mem_responder #(.WAIT_STATES(1)) u_ws1 (.clk(clk), .rst_n(rst_n), .bus(if_ws1));
    data_mem_responder #(.WAIT_STATES(3)) u_ws3 (.clk(clk), .rst_n(rst_n), .bus(if_ws3));

    assign if_ws0.data_memory_a     = a_v[0];
    assign if_ws0.data_memory_out_v = d_v[0];
    assign if_ws0.data_memory_read  = rd_v[0];
    assign if_ws0.data_memory_write = wr_v[0];
    assign in_v[0]   = if_ws0.data_memory_in_v;
    assign busy_v[0] = if_ws0.mem_busy;
    assign done_v[0] = if_ws0.mem_done;
    assign err_v[0]  = if_ws0.mem_err;

    assign if_ws1.data_memory_a     = a_v[1];
    assign if_ws1.data_memory_out_v = d_v[1];
    assign if_ws1.data_memory_read  = rd_v[1];
    assign if_ws1.data_memory_write = wr_v[1];
    assign in_v[1]   = if_ws1.data_memory_in_v;
    assign busy_v[1] = if_ws1.mem_busy;
    assign done_v[1] = if_ws1.mem_done;
    assign err_v[1]  = if_ws1.mem_err;

    assign if_ws3.data_memory_a     = a_v[2];
    assign if_ws3.data_memory_out_v = d_v[2];
    assign if_ws3.data_memory_read  = rd_v[2];
    assign if_ws3.data_memory_write = wr_v[2];
    assign in_v[2]   = if_ws3.data_memory_in_v;
    assign busy_v[2] = if_ws3.mem_busy;
    assign done_v[2] = if_ws3.mem_done;
    assign err_v[2]  = if_ws3.mem_err;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One access: request is scrambled and dropped right after capture; cycle count starts at 1.
    task automatic run_access(input int k, input logic rd, input logic wr,
                              input logic [31:0] addr, input logic [31:0] data,
                              output int lat, output logic err, output logic [31:0] rdata,
                              output logic busy_ok, output logic idle_ok);
        a_v[k]  = addr;
        d_v[k]  = data;
        rd_v[k] = rd;
        wr_v[k] = wr;
        step();
        a_v[k]  = 32'h44;
        d_v[k]  = 32'hBAD0_BAD0;
        rd_v[k] = 1'b0;
        wr_v[k] = 1'b0;
        lat     = -1;
        err     = 1'bx;
        rdata   = 32'hx;
        busy_ok = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            if (busy_v[k] !== 1'b1) busy_ok = 1'b0;
            if (done_v[k] === 1'b1) begin
                lat   = c;
                err   = err_v[k];
                rdata = in_v[k];
                break;
            end
            step();
        end
        step();
        idle_ok = (done_v[k] === 1'b0) && (busy_v[k] === 1'b0);
    endtask

    task automatic wait_done(input int k, output int cyc);
        cyc = -1;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (done_v[k] === 1'b1) begin
                cyc = c;
                break;
            end
        end
    endtask

    initial begin
        int          lat;
        int          cyc;
        int          ndone;
        int          nbusy;
        logic        err;
        logic [31:0] rdata;
        logic        busy_ok;
        logic        idle_ok;

        for (int i = 0; i < 3; i++) begin
            a_v[i] = '0; d_v[i] = '0; rd_v[i] = 1'b0; wr_v[i] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ws0_outputs", {in_v[0][28:0], busy_v[0], done_v[0], err_v[0]}, 32'h0);
        chk("reset_ws1_outputs", {in_v[1][28:0], busy_v[1], done_v[1], err_v[1]}, 32'h0);
        chk("reset_ws3_outputs", {in_v[2][28:0], busy_v[2], done_v[2], err_v[2]}, 32'h0);
        rst_n = 1'b1;
        step();

        // Write then read with one wait state
        run_access(1, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, lat, err, rdata, busy_ok, idle_ok);
        chk("wr10_latency", lat, 32'd2);
        chk("wr10_err", {31'd0, err}, 32'd0);
        chk("wr10_busy_span", {31'd0, busy_ok}, 32'd1);
        chk("wr10_idle_after", {31'd0, idle_ok}, 32'd1);
        run_access(1, 1'b1, 1'b0, 32'h10, 32'h0, lat, err, rdata, busy_ok, idle_ok);
        chk("rd10_latency", lat, 32'd2);
        chk("rd10_err", {31'd0, err}, 32'd0);
        chk("rd10_data", rdata, 32'hDEAD_BEEF);
        chk("rd10_data_held", in_v[1], 32'hDEAD_BEEF);

        // Rejected requests
        run_access(1, 1'b1, 1'b0, 32'h13, 32'h0, lat, err, rdata, busy_ok, idle_ok);
        chk("misaligned_err", {31'd0, err}, 32'd1);
        chk("misaligned_latency", lat, 32'd2);
        chk("misaligned_data_kept", rdata, 32'hDEAD_BEEF);
        run_access(1, 1'b1, 1'b0, 32'h1000, 32'h0, lat, err, rdata, busy_ok, idle_ok);
        chk("out_of_range_err", {31'd0, err}, 32'd1);
        chk("out_of_range_data_kept", rdata, 32'hDEAD_BEEF);
        run_access(1, 1'b1, 1'b1, 32'h10, 32'h1234_5678, lat, err, rdata, busy_ok, idle_ok);
        chk("rd_and_wr_err", {31'd0, err}, 32'd1);
        run_access(1, 1'b1, 1'b0, 32'h10, 32'h0, lat, err, rdata, busy_ok, idle_ok);
        chk("rd_and_wr_no_ram_change", rdata, 32'hDEAD_BEEF);
        chk("rd10_again_err", {31'd0, err}, 32'd0);
        run_access(1, 1'b1, 1'b0, 32'hFFC, 32'h0, lat, err, rdata, busy_ok, idle_ok);
        chk("last_word_ok", {31'd0, err}, 32'd0);

        // Latency sweep
        run_access(0, 1'b0, 1'b1, 32'h100, 32'hCAFE_0001, lat, err, rdata, busy_ok, idle_ok);
        chk("ws0_wr_latency", lat, 32'd1);
        chk("ws0_wr_busy_span", {31'd0, busy_ok}, 32'd1);
        run_access(0, 1'b1, 1'b0, 32'h100, 32'h0, lat, err, rdata, busy_ok, idle_ok);
        chk("ws0_rd_latency", lat, 32'd1);
        chk("ws0_rd_data", rdata, 32'hCAFE_0001);
        chk("ws0_idle_after", {31'd0, idle_ok}, 32'd1);
        run_access(2, 1'b0, 1'b1, 32'h3C, 32'h0BAD_F00D, lat, err, rdata, busy_ok, idle_ok);
        chk("ws3_wr_latency", lat, 32'd4);
        chk("ws3_wr_busy_span", {31'd0, busy_ok}, 32'd1);
        chk("ws3_idle_after", {31'd0, idle_ok}, 32'd1);
        run_access(2, 1'b1, 1'b0, 32'h3C, 32'h0, lat, err, rdata, busy_ok, idle_ok);
        chk("ws3_rd_latency", lat, 32'd4);
        chk("ws3_rd_data", rdata, 32'h0BAD_F00D);

        // Address/data changed and request dropped during WAIT
        run_access(1, 1'b0, 1'b1, 32'h20, 32'h1111, lat, err, rdata, busy_ok, idle_ok);
        chk("drop_mid_wait_done", lat, 32'd2);
        run_access(1, 1'b1, 1'b0, 32'h20, 32'h0, lat, err, rdata, busy_ok, idle_ok);
        chk("drop_mid_wait_readback", rdata, 32'h1111);

        // Reset during the WAIT of a write abandons it
        run_access(1, 1'b0, 1'b1, 32'h8, 32'hA5A5, lat, err, rdata, busy_ok, idle_ok);
        a_v[1] = 32'h8; d_v[1] = 32'h5A5A; wr_v[1] = 1'b1;
        step();
        wr_v[1] = 1'b0;
        chk("pre_reset_busy", {31'd0, busy_v[1]}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_outputs", {in_v[1][28:0], busy_v[1], done_v[1], err_v[1]}, 32'h0);
        chk("mid_reset_data_out", in_v[1], 32'h0);
        step();
        step();
        rst_n = 1'b1;
        step();
        run_access(1, 1'b1, 1'b0, 32'h8, 32'h0, lat, err, rdata, busy_ok, idle_ok);
        chk("reset_write_abandoned", rdata, 32'hA5A5);

        // Request held through the IDLE cycle after mem_done repeats the access
        a_v[1] = 32'h10; rd_v[1] = 1'b1;
        wait_done(1, cyc);
        chk("b2b_first_done", cyc, 32'd2);
        chk("b2b_first_data", in_v[1], 32'hDEAD_BEEF);
        step();
        chk("b2b_idle_gap_busy", {31'd0, busy_v[1]}, 32'd0);
        step();
        chk("b2b_second_started", {31'd0, busy_v[1]}, 32'd1);
        rd_v[1] = 1'b0;
        ndone = 0;
        for (int c = 0; c < 6; c++) begin
            if (done_v[1] === 1'b1) ndone++;
            step();
        end
        chk("b2b_second_done_count", ndone, 32'd1);
        chk("b2b_second_data", in_v[1], 32'hDEAD_BEEF);

        // Dropping on mem_done gives exactly one access
        rd_v[1] = 1'b1;
        wait_done(1, cyc);
        rd_v[1] = 1'b0;
        chk("single_done", cyc, 32'd2);
        ndone = 0;
        nbusy = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (done_v[1] === 1'b1) ndone++;
            if (busy_v[1] === 1'b1) nbusy++;
        end
        chk("single_no_repeat_done", ndone, 32'd0);
        chk("single_no_repeat_busy", nbusy, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
